// File: rtl/a2d_spi_responder_if.sv
// -----------------------------------------------------------------------------
// a2d_spi_responder_if
//   SPI bus between the A2D polling monarch and the emulated A2D converter.
//
//   Signals:
//     SS_n  serf select, active low   (monarch -> serf)
//     SCLK  serial clock, idles high   (monarch -> serf)
//     MOSI  command data, MSB first    (monarch -> serf)
//     MISO  response data, MSB first   (serf -> monarch)
//
//   Modports:
//     master  the SPI monarch (drives SS_n/SCLK/MOSI)
//     slave   the A2D responder (drives MISO)
// -----------------------------------------------------------------------------
interface a2d_spi_responder_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface : a2d_spi_responder_if

// File: rtl/a2d_spi_responder.sv
// -----------------------------------------------------------------------------
// a2d_spi_responder
//   SPI serf emulating an 8-channel 12-bit A2D converter. Each 16-bit frame
//   carries a channel select in cmd[13:11]; the response is the value of the
//   channel selected by the previous complete frame (one-frame pipeline).
//   The sample is frozen when SS_n falls.
//
//   Parameters:
//     NUM_CH       number of channels (1..8); channel indices >= NUM_CH read 0
//     SYNC_STAGES  synchronizer depth on SS_n/SCLK/MOSI (>= 2)
//
//   Ports:
//     clk, rst_n   system clock, asynchronous active-low reset
//     spi          SPI bus (slave modport): SS_n, SCLK, MOSI in; MISO out
//     ch_data      flattened channel values, channel n at [12n+11:12n]
//     cmd_vld      one-clk pulse after a complete 16-bit frame
//     cur_chnl     channel from the last complete command
//     trans_cnt    complete frame count (wraps)
//     frm_err      sticky frame error
//
//   Optional feature (macro A2D_CMD_CHK_EN):
//     defined   a complete frame with non-zero reserved bits (rx[15:14],
//               rx[10:0]) also sets frm_err; cur_chnl/cmd_vld still update
//     undefined reserved bits are ignored
// -----------------------------------------------------------------------------
module a2d_spi_responder #(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  a2d_spi_responder_if.slave      spi,
  input  logic [12*NUM_CH-1:0]    ch_data,
  output logic                    cmd_vld,
  output logic [2:0]              cur_chnl,
  output logic [15:0]             trans_cnt,
  output logic                    frm_err
);

  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_q,      state_d;
  logic [SYNC_STAGES-1:0] ss_sync_q,    ss_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q,  sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q,  mosi_sync_d;
  logic                   ss_prev_q,    ss_prev_d;
  logic                   sclk_prev_q,  sclk_prev_d;
  logic [FLUSH_W-1:0]     flush_cnt_q,  flush_cnt_d;
  logic                   armed_q,      armed_d;
  logic [15:0]            tx_shft_q,    tx_shft_d;
  logic [15:0]            rx_shft_q,    rx_shft_d;
  logic [4:0]             bit_cnt_q,    bit_cnt_d;
  logic                   first_fall_q, first_fall_d;
  logic                   overrun_q,    overrun_d;
  logic                   cmd_vld_q,    cmd_vld_d;
  logic [2:0]             cur_chnl_q,   cur_chnl_d;
  logic [15:0]            trans_cnt_q,  trans_cnt_d;
  logic                   frm_err_q,    frm_err_d;

  logic        ss_s, sclk_s, mosi_s;
  logic        ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic        flushed;
  logic [11:0] sample;

  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign ss_fall   =  ss_prev_q   & ~ss_s;
  assign ss_rise   = ~ss_prev_q   &  ss_s;
  assign sclk_rise = ~sclk_prev_q &  sclk_s;
  assign sclk_fall =  sclk_prev_q & ~sclk_s;

  // The synchronizers reset to "SS_n high", so right after reset an SS_n that
  // is physically low would look like a fresh fall. A frame may only start
  // once the chain holds real pin samples and SS_n has been seen high.
  assign flushed = (flush_cnt_q == FLUSH_W'(SYNC_STAGES));

  assign spi.MISO = ss_s ? 1'b0 : tx_shft_q[15];

  assign cmd_vld   = cmd_vld_q;
  assign cur_chnl  = cur_chnl_q;
  assign trans_cnt = trans_cnt_q;
  assign frm_err   = frm_err_q;

  // Channel mux; indices with no channel behind them read as zero.
  always_comb begin
    sample = 12'h000;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cur_chnl_q == 3'(i)) sample = ch_data[12*i +: 12];
    end
  end

`ifdef A2D_CMD_CHK_EN
  logic rsvd_bad;
  assign rsvd_bad = (rx_shft_q[15:14] != 2'b00) || (rx_shft_q[10:0] != 11'h000);
`else
  logic unused_rsvd;
  assign unused_rsvd = ^{rx_shft_q[15:14], rx_shft_q[10:0]};
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    ss_sync_d    = {ss_sync_q[SYNC_STAGES-2:0],   spi.SS_n};
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
    mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
    ss_prev_d    = ss_s;
    sclk_prev_d  = sclk_s;
    flush_cnt_d  = flushed ? flush_cnt_q : flush_cnt_q + FLUSH_W'(1);
    armed_d      = armed_q | (flushed & ss_s);
    tx_shft_d    = tx_shft_q;
    rx_shft_d    = rx_shft_q;
    bit_cnt_d    = bit_cnt_q;
    first_fall_d = first_fall_q;
    overrun_d    = overrun_q;
    cmd_vld_d    = 1'b0;
    cur_chnl_d   = cur_chnl_q;
    trans_cnt_d  = trans_cnt_q;
    frm_err_d    = frm_err_q;

    unique case (state_q)
      IDLE: begin
        if (ss_fall && armed_q) begin
          state_d      = SHIFT;
          tx_shft_d    = {4'h0, sample};
          rx_shft_d    = 16'h0000;
          bit_cnt_d    = 5'd0;
          first_fall_d = 1'b0;
          overrun_d    = 1'b0;
        end
      end
      SHIFT: begin
        // SS_n rise has priority: a coincident SCLK edge is dropped.
        if (ss_rise) begin
          state_d   = IDLE;
          tx_shft_d = 16'h0000;
          if (bit_cnt_q == 5'd16 && !overrun_q) begin
            cmd_vld_d   = 1'b1;
            cur_chnl_d  = rx_shft_q[13:11];
            trans_cnt_d = trans_cnt_q + 16'd1;
`ifdef A2D_CMD_CHK_EN
            if (rsvd_bad) frm_err_d = 1'b1;
`endif
          end else begin
            frm_err_d = 1'b1;
          end
        end else if (sclk_rise) begin
          if (bit_cnt_q == 5'd16) begin
            overrun_d = 1'b1;
          end else begin
            rx_shft_d = {rx_shft_q[14:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else if (sclk_fall) begin
          // The MSB is already on MISO at SS_n fall; the first SCLK fall
          // (before any rise) must not shift it away.
          if (!first_fall_q) first_fall_d = 1'b1;
          else               tx_shft_d    = {tx_shft_q[14:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // update together from values computed in the previous cycle.
  // NOTE: every flop here is control/datapath state with a defined reset
  // value; there is no memory array that would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ss_sync_q    <= '1;
      sclk_sync_q  <= '1;
      mosi_sync_q  <= '0;
      ss_prev_q    <= 1'b1;
      sclk_prev_q  <= 1'b1;
      flush_cnt_q  <= '0;
      armed_q      <= 1'b0;
      tx_shft_q    <= 16'h0000;
      rx_shft_q    <= 16'h0000;
      bit_cnt_q    <= 5'd0;
      first_fall_q <= 1'b0;
      overrun_q    <= 1'b0;
      cmd_vld_q    <= 1'b0;
      cur_chnl_q   <= 3'd0;
      trans_cnt_q  <= 16'h0000;
      frm_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ss_sync_q    <= ss_sync_d;
      sclk_sync_q  <= sclk_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      ss_prev_q    <= ss_prev_d;
      sclk_prev_q  <= sclk_prev_d;
      flush_cnt_q  <= flush_cnt_d;
      armed_q      <= armed_d;
      tx_shft_q    <= tx_shft_d;
      rx_shft_q    <= rx_shft_d;
      bit_cnt_q    <= bit_cnt_d;
      first_fall_q <= first_fall_d;
      overrun_q    <= overrun_d;
      cmd_vld_q    <= cmd_vld_d;
      cur_chnl_q   <= cur_chnl_d;
      trans_cnt_q  <= trans_cnt_d;
      frm_err_q    <= frm_err_d;
    end
  end

endmodule : a2d_spi_responder

// File: tb/tb_a2d_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_a2d_spi_responder
//   Self-checking bench for a2d_spi_responder. Drives SPI frames as a monarch
//   and compares responses and status against a frame-level reference model.
//   Built with NUM_CH=6 so that channel selects 6 and 7 exercise the
//   "no such channel reads zero" rule.
// -----------------------------------------------------------------------------
module tb_a2d_spi_responder;

  localparam int NUM_CH = 6;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [12*NUM_CH-1:0] ch_flat;
  logic                 cmd_vld;
  logic [2:0]           cur_chnl;
  logic [15:0]          trans_cnt;
  logic                 frm_err;

  logic [11:0] chv [8];

  int checks   = 0;
  int failures = 0;
  int vld_cnt  = 0;

  // Reference model state (frame level).
  logic [2:0]  cur_m;
  logic [15:0] trans_m;
  logic        err_m;

  a2d_spi_responder_if spi ();

  a2d_spi_responder #(.NUM_CH(NUM_CH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi.slave),
    .ch_data   (ch_flat),
    .cmd_vld   (cmd_vld),
    .cur_chnl  (cur_chnl),
    .trans_cnt (trans_cnt),
    .frm_err   (frm_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    ch_flat = '0;
    for (int i = 0; i < NUM_CH; i++) ch_flat[12*i +: 12] = chv[i];
  end

  always @(negedge clk) if (cmd_vld === 1'b1) vld_cnt++;

  // ---------------------------------------------------------------- model ---
  function automatic logic [15:0] ref_word(input logic [2:0] ch);
    return (int'(ch) < NUM_CH) ? {4'h0, chv[ch]} : 16'h0000;
  endfunction

  task automatic model_reset();
    cur_m = 3'd0; trans_m = 16'h0000; err_m = 1'b0;
  endtask

  task automatic model_complete(input logic [15:0] cmd);
    cur_m   = cmd[13:11];
    trans_m = trans_m + 16'd1;
`ifdef A2D_CMD_CHK_EN
    if (cmd[15:14] != 2'b00 || cmd[10:0] != 11'h000) err_m = 1'b1;
`endif
  endtask

  // --------------------------------------------------------------- driver ---
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ss_low();
    spi.SS_n = 1'b0;
    wait_clk(8);
  endtask

  task automatic ss_high();
    spi.SS_n = 1'b1;
    wait_clk(10);
  endtask

  // One SCLK period: fall + drive MOSI, sample MISO just before the rise.
  task automatic spi_bit(input logic b, output logic m);
    spi.SCLK = 1'b0;
    spi.MOSI = b;
    wait_clk(6);
    m = spi.MISO;
    spi.SCLK = 1'b1;
    wait_clk(6);
  endtask

  // Full 16-bit frame; returns received word, model expectation and the
  // number of cmd_vld cycles seen; updates the model.
  task automatic full_frame(input logic [15:0] cmd, output logic [15:0] rx,
                            output logic [15:0] exp, output int vld);
    int v0;
    v0  = vld_cnt;
    exp = ref_word(cur_m);
    ss_low();
    for (int i = 15; i >= 0; i--) spi_bit(cmd[i], rx[i]);
    ss_high();
    vld = vld_cnt - v0;
    model_complete(cmd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(6);
    model_reset();
  endtask

  // ---------------------------------------------------------------- tests ---
  task automatic test_reset();
    do_reset();
    checks++; if (spi.MISO !== 1'b0)    begin failures++; $display("FAIL reset_miso got=%b exp=0", spi.MISO); end
    checks++; if (cmd_vld !== 1'b0)     begin failures++; $display("FAIL reset_cmd_vld got=%b exp=0", cmd_vld); end
    checks++; if (cur_chnl !== 3'd0)    begin failures++; $display("FAIL reset_cur_chnl got=%0d exp=0", cur_chnl); end
    checks++; if (trans_cnt !== 16'h0)  begin failures++; $display("FAIL reset_trans_cnt got=%h exp=0", trans_cnt); end
    checks++; if (frm_err !== 1'b0)     begin failures++; $display("FAIL reset_frm_err got=%b exp=0", frm_err); end
  endtask

  task automatic test_basic();
    logic [15:0] rx, exp;
    int vld;
    chv[0] = 12'h5A5;
    chv[1] = 12'hABC;
    full_frame(16'h0800, rx, exp, vld);
    checks++; if (rx !== 16'h05A5)    begin failures++; $display("FAIL basic_rx1 got=%h exp=05a5", rx); end
    checks++; if (vld != 1)           begin failures++; $display("FAIL basic_vld1 got=%0d exp=1", vld); end
    checks++; if (cur_chnl !== 3'd1)  begin failures++; $display("FAIL basic_cur1 got=%0d exp=1", cur_chnl); end
    checks++; if (trans_cnt !== 16'd1) begin failures++; $display("FAIL basic_trans1 got=%0d exp=1", trans_cnt); end
    full_frame(16'h0000, rx, exp, vld);
    checks++; if (rx !== 16'h0ABC)    begin failures++; $display("FAIL basic_rx2 got=%h exp=0abc", rx); end
    checks++; if (cur_chnl !== 3'd0)  begin failures++; $display("FAIL basic_cur2 got=%0d exp=0", cur_chnl); end
  endtask

  task automatic test_poll();
    logic [15:0] rx, exp;
    int vld;
    logic [2:0] seq [5];
    logic [15:0] t0;
    seq = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd0};
    chv[3] = 12'h123;
    chv[4] = 12'hFFF;
    t0 = trans_cnt;
    for (int k = 0; k < 5; k++) begin
      full_frame({2'b00, seq[k], 11'h000}, rx, exp, vld);
      checks++; if (rx !== exp) begin failures++; $display("FAIL poll_rx[%0d] got=%h exp=%h", k, rx, exp); end
      checks++; if (vld != 1)   begin failures++; $display("FAIL poll_vld[%0d] got=%0d exp=1", k, vld); end
    end
    checks++; if (trans_cnt !== t0 + 16'd5) begin failures++; $display("FAIL poll_trans got=%0d exp=%0d", trans_cnt, t0 + 16'd5); end
    checks++; if (frm_err !== 1'b0)        begin failures++; $display("FAIL poll_frm_err got=%b exp=0", frm_err); end
  endtask

  task automatic test_random();
    logic [15:0] rx, exp, cmd;
    int vld;
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < 8; c++) chv[c] = 12'($urandom);
      cmd = 16'($urandom);
`ifdef A2D_CMD_CHK_EN
      if (k % 2 == 0) cmd = cmd & 16'h3800;
`endif
      full_frame(cmd, rx, exp, vld);
      checks++; if (rx !== exp)           begin failures++; $display("FAIL rand_rx[%0d] got=%h exp=%h", k, rx, exp); end
      checks++; if (vld != 1)             begin failures++; $display("FAIL rand_vld[%0d] got=%0d exp=1", k, vld); end
      checks++; if (cur_chnl !== cur_m)   begin failures++; $display("FAIL rand_cur[%0d] got=%0d exp=%0d", k, cur_chnl, cur_m); end
      checks++; if (trans_cnt !== trans_m) begin failures++; $display("FAIL rand_trans[%0d] got=%0d exp=%0d", k, trans_cnt, trans_m); end
      checks++; if (frm_err !== err_m)    begin failures++; $display("FAIL rand_frm_err[%0d] got=%b exp=%b", k, frm_err, err_m); end
    end
  endtask

  task automatic test_reserved();
    logic [15:0] rx, exp;
    int vld;
    full_frame(16'hC801, rx, exp, vld);
    checks++; if (rx !== exp)          begin failures++; $display("FAIL rsvd_rx got=%h exp=%h", rx, exp); end
    checks++; if (vld != 1)            begin failures++; $display("FAIL rsvd_vld got=%0d exp=1", vld); end
    checks++; if (cur_chnl !== 3'd1)   begin failures++; $display("FAIL rsvd_cur got=%0d exp=1", cur_chnl); end
    checks++; if (frm_err !== err_m)   begin failures++; $display("FAIL rsvd_frm_err got=%b exp=%b", frm_err, err_m); end
  endtask

  task automatic test_data_change();
    logic [15:0] rx, exp, cmd;
    int vld;
    cmd = {2'b00, 3'd2, 11'h000};
    full_frame(cmd, rx, exp, vld);
    chv[2] = 12'h111;
    exp = ref_word(cur_m);
    ss_low();
    for (int i = 15; i >= 8; i--) spi_bit(cmd[i], rx[i]);
    chv[2] = 12'h222;
    for (int i = 7; i >= 0; i--) spi_bit(cmd[i], rx[i]);
    ss_high();
    model_complete(cmd);
    checks++; if (rx !== 16'h0111) begin failures++; $display("FAIL chg_cur_frame got=%h exp=0111", rx); end
    checks++; if (rx !== exp)      begin failures++; $display("FAIL chg_cur_model got=%h exp=%h", rx, exp); end
    full_frame(cmd, rx, exp, vld);
    checks++; if (rx !== 16'h0222) begin failures++; $display("FAIL chg_next_frame got=%h exp=0222", rx); end
  endtask

  task automatic test_short_frame();
    logic [15:0] rx, exp, cmd;
    logic [2:0]  cur0;
    logic [15:0] t0;
    int v0, vld;
    cur0 = cur_chnl;
    t0   = trans_cnt;
    v0   = vld_cnt;
    cmd  = {2'b00, 3'd5, 11'h000};
    ss_low();
    for (int i = 15; i >= 7; i--) spi_bit(cmd[i], rx[i]);
    ss_high();
    err_m = 1'b1;
    checks++; if (frm_err !== 1'b1)  begin failures++; $display("FAIL short_frm_err got=%b exp=1", frm_err); end
    checks++; if (vld_cnt != v0)     begin failures++; $display("FAIL short_no_vld got=%0d exp=0", vld_cnt - v0); end
    checks++; if (cur_chnl !== cur_m) begin failures++; $display("FAIL short_cur got=%0d exp=%0d", cur_chnl, cur_m); end
    checks++; if (cur_chnl !== cur0) begin failures++; $display("FAIL short_cur_hold got=%0d exp=%0d", cur_chnl, cur0); end
    checks++; if (trans_cnt !== t0)  begin failures++; $display("FAIL short_trans got=%0d exp=%0d", trans_cnt, t0); end
    full_frame(16'h0800, rx, exp, vld);
    checks++; if (rx !== exp)        begin failures++; $display("FAIL short_next_rx got=%h exp=%h", rx, exp); end
    checks++; if (frm_err !== 1'b1)  begin failures++; $display("FAIL short_sticky got=%b exp=1", frm_err); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] rx, exp, cmd;
    logic        m, any_one;
    int v0, vld;
    cmd = {2'b00, 3'd3, 11'h000};
    ss_low();
    for (int i = 15; i >= 11; i--) spi_bit(cmd[i], rx[i]);
    rst_n = 1'b0;
    wait_clk(3);
    checks++; if (spi.MISO !== 1'b0) begin failures++; $display("FAIL rstmid_miso_in_rst got=%b exp=0", spi.MISO); end
    rst_n = 1'b1;
    model_reset();
    v0 = vld_cnt;
    wait_clk(4);
    any_one = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      spi_bit(cmd[i], m);
      if (m !== 1'b0) any_one = 1'b1;
    end
    ss_high();
    checks++; if (any_one !== 1'b0)  begin failures++; $display("FAIL rstmid_miso got=%b exp=0", any_one); end
    checks++; if (vld_cnt != v0)     begin failures++; $display("FAIL rstmid_no_vld got=%0d exp=0", vld_cnt - v0); end
    checks++; if (frm_err !== 1'b0)  begin failures++; $display("FAIL rstmid_frm_err got=%b exp=0", frm_err); end
    checks++; if (trans_cnt !== 16'h0) begin failures++; $display("FAIL rstmid_trans got=%0d exp=0", trans_cnt); end
    chv[0] = 12'h3C7;
    full_frame(16'h0800, rx, exp, vld);
    checks++; if (rx !== 16'h03C7)   begin failures++; $display("FAIL rstmid_clean_rx got=%h exp=03c7", rx); end
    checks++; if (vld != 1)          begin failures++; $display("FAIL rstmid_clean_vld got=%0d exp=1", vld); end
    checks++; if (cur_chnl !== 3'd1) begin failures++; $display("FAIL rstmid_clean_cur got=%0d exp=1", cur_chnl); end
    checks++; if (trans_cnt !== 16'd1) begin failures++; $display("FAIL rstmid_clean_trans got=%0d exp=1", trans_cnt); end
  endtask

  initial begin
    spi.SS_n = 1'b1;
    spi.SCLK = 1'b1;
    spi.MOSI = 1'b0;
    for (int c = 0; c < 8; c++) chv[c] = 12'h000;
    model_reset();
    test_reset();
    test_basic();
    test_poll();
    test_random();
    test_reserved();
    test_data_change();
    test_short_frame();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_a2d_spi_responder
